multi_debouncer: RTL and testbench

- Parametrised, multi-channel successor to the single-input button debouncer. Serves banks of switches and buttons on the board I/O path.
- Each channel gets a metastability synchroniser, a debounce filter, one-cycle rise/fall strobes and a long-press ("held") strobe.
- Outputs feed UI/control FSMs directly; no further synchronisation or edge detection is needed downstream.

---
 rtl/multi_debouncer.sv | 124 ++++++++++++
 tb/tb_multi_debouncer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// Multi-channel switch/button debouncer: per-channel synchroniser, debounce
// filter, one-cycle rise/fall strobes and a one-shot long-press strobe.
module multi_debouncer #(
   parameter int CHANNELS         = 4,
   parameter int CLK_PERIOD_NS    = 10,
   parameter int DEBOUNCE_TIME_NS = 7000,
   parameter int HOLD_TIME_NS     = 1000000,
   parameter int SYNC_STAGES      = 2
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic [CHANNELS-1:0] dirty_in,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise_out,
   output logic [CHANNELS-1:0] fall_out,
   output logic [CHANNELS-1:0] held_out,
   output logic                changed_out
);

   localparam int COUNTER_RAW = (DEBOUNCE_TIME_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
   localparam int COUNTER_MAX = (COUNTER_RAW < 1) ? 1 : COUNTER_RAW;
   localparam int HOLD_MAX    = (HOLD_TIME_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
   localparam int CNT_W       = $clog2(COUNTER_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTER_MAX - 1);

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_s;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CHANNELS-1:0] clean_q;
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] fall_q;
   logic [CHANNELS-1:0] flip;
   logic                changed_q;

   // NOTE: the synchroniser is a small flop array, not a RAM, so every stage
   // takes the asynchronous reset like any other state.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int st = 0; st < SYNC_STAGES; st++) sync_q[st] <= '0;
      end else begin
         sync_q[0] <= dirty_in;
         for (int st = 1; st < SYNC_STAGES; st++) sync_q[st] <= sync_q[st-1];
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // A channel flips when its synchronised level has disagreed with the clean
   // level for COUNTER_MAX consecutive edges.
   always_comb begin
      // NOTE: default assignment first so no path leaves flip unassigned,
      // which would otherwise infer a latch.
      flip = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         flip[i] = (sync_s[i] != clean_q[i]) && (cnt_q[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         clean_q   <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every read below sees the
         // pre-edge value, matching the flops that get built.
         for (int i = 0; i < CHANNELS; i++) begin
            if ((sync_s[i] == clean_q[i]) || flip[i]) cnt_q[i] <= '0;
            else                                      cnt_q[i] <= cnt_q[i] + 1'b1;
         end
         clean_q   <= clean_q ^ flip;
         rise_q    <= flip & sync_s;
         fall_q    <= flip & ~sync_s;
         changed_q <= |flip;
      end
   end

   assign clean_out   = clean_q;
   assign rise_out    = rise_q;
   assign fall_out    = fall_q;
   assign changed_out = changed_q;

   generate
      if (HOLD_MAX > 0) begin : g_hold
         localparam int HCNT_W = $clog2(HOLD_MAX + 1);
         localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_MAX - 1);

         logic [HCNT_W-1:0]   hcnt_q [CHANNELS];
         logic [CHANNELS-1:0] fired_q;
         logic [CHANNELS-1:0] held_q;

         // fired_q keeps a long press to a single strobe until the key is released.
         always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
               fired_q <= '0;
               held_q  <= '0;
               for (int i = 0; i < CHANNELS; i++) hcnt_q[i] <= '0;
            end else begin
               for (int i = 0; i < CHANNELS; i++) begin
                  held_q[i] <= 1'b0;
                  if (!clean_q[i]) begin
                     hcnt_q[i]  <= '0;
                     fired_q[i] <= 1'b0;
                  end else if (!fired_q[i]) begin
                     if (hcnt_q[i] == HCNT_LAST) begin
                        held_q[i]  <= 1'b1;
                        fired_q[i] <= 1'b1;
                     end else begin
                        hcnt_q[i] <= hcnt_q[i] + 1'b1;
                     end
                  end
               end
            end
         end

         assign held_out = held_q;
      end else begin : g_no_hold
         assign held_out = '0;
      end
   endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed scenarios with literal
// expectations plus randomized bouncing inputs checked against a window model.
module tb_multi_debouncer;

   localparam int N    = 4;
   localparam int CM   = 5;
   localparam int HM   = 20;
   localparam int SYNC = 2;

   logic         clk_in;
   logic         rst_n_in;
   logic [N-1:0] dirty_in;
   logic [N-1:0] clean_out;
   logic [N-1:0] rise_out;
   logic [N-1:0] fall_out;
   logic [N-1:0] held_out;
   logic         changed_out;

   int n_checks = 0;
   int n_pass   = 0;

   multi_debouncer #(
      .CHANNELS         (N),
      .CLK_PERIOD_NS    (10),
      .DEBOUNCE_TIME_NS (50),
      .HOLD_TIME_NS     (200),
      .SYNC_STAGES      (SYNC)
   ) dut (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .dirty_in    (dirty_in),
      .clean_out   (clean_out),
      .rise_out    (rise_out),
      .fall_out    (fall_out),
      .held_out    (held_out),
      .changed_out (changed_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Model: last CM synchronised samples per channel; the clean level flips
   // once all of them disagree with it. run = cycles the clean level has been high.
   typedef struct packed {
      logic [SYNC-1:0][N-1:0] sync;
      logic [CM-1:0][N-1:0]   win;
      logic [N-1:0][7:0]      run;
      logic [N-1:0]           clean;
      logic [N-1:0]           rise;
      logic [N-1:0]           fall;
      logic [N-1:0]           held;
      logic                   changed;
   } model_t;

   model_t m = '0;

   function automatic model_t model_step(input model_t cur, input logic [N-1:0] d);
      model_t nxt;
      logic   all_diff;
      nxt      = cur;
      nxt.win  = {cur.win[CM-2:0], cur.sync[SYNC-1]};
      nxt.sync = {cur.sync[SYNC-2:0], d};
      nxt.rise = '0;
      nxt.fall = '0;
      nxt.held = '0;
      for (int ch = 0; ch < N; ch++) begin
         all_diff = 1'b1;
         for (int k = 0; k < CM; k++) if (nxt.win[k][ch] == cur.clean[ch]) all_diff = 1'b0;
         if (all_diff) begin
            nxt.clean[ch] = ~cur.clean[ch];
            nxt.rise[ch]  = ~cur.clean[ch];
            nxt.fall[ch]  = cur.clean[ch];
         end
         nxt.held[ch] = cur.clean[ch] && (cur.run[ch] == 8'(HM));
         if (!nxt.clean[ch])            nxt.run[ch] = '0;
         else if (cur.run[ch] <= 8'(HM)) nxt.run[ch] = cur.run[ch] + 8'd1;
      end
      nxt.changed = |(nxt.rise | nxt.fall);
      return nxt;
   endfunction

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) m <= '0;
      else           m <= model_step(m, dirty_in);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk_in) begin
      check("cmp_clean",   32'(clean_out),   32'(m.clean));
      check("cmp_rise",    32'(rise_out),    32'(m.rise));
      check("cmp_fall",    32'(fall_out),    32'(m.fall));
      check("cmp_held",    32'(held_out),    32'(m.held));
      check("cmp_changed", 32'(changed_out), 32'(m.changed));
   end

   // Leaves the bench 1 time unit after the n-th following rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      check(name, 32'({clean_out, rise_out, fall_out, held_out, changed_out}), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int         left   [N];
   int         bounce [N];
   logic       tgt    [N];
   logic [N-1:0] d;

   initial begin
      rst_n_in = 1'b1;
      dirty_in = 4'b1111;
      #1 rst_n_in = 1'b0;
      tick(3);
      check_all_zero("s1_reset_outputs");

      // Scenario 1: inputs high through reset, rise on edge 7 after release.
      rst_n_in = 1'b1;
      tick(6);
      check("s1_edge6_clean", 32'(clean_out), 32'h0);
      tick(1);
      check("s1_edge7_clean",   32'(clean_out),   32'hf);
      check("s1_edge7_rise",    32'(rise_out),    32'hf);
      check("s1_edge7_changed", 32'(changed_out), 32'h1);
      tick(1);
      check("s1_edge8_rise",    32'(rise_out),    32'h0);
      check("s1_edge8_changed", 32'(changed_out), 32'h0);
      tick(18);
      check("s1_hold_early", 32'(held_out), 32'h0);
      tick(1);
      check("s1_hold_fire", 32'(held_out), 32'hf);
      tick(1);
      check("s1_hold_once", 32'(held_out), 32'h0);
      dirty_in = 4'b0000;
      tick(7);
      check("s1_fall_all", 32'(fall_out), 32'hf);

      // Scenario 2: 4-cycle glitch rejected, then a real press.
      tick(3);
      dirty_in = 4'b0001;
      tick(4);
      dirty_in = 4'b0000;
      tick(12);
      check("s2_glitch_clean", 32'(clean_out), 32'h0);
      dirty_in = 4'b0001;
      tick(6);
      check("s2_edge6_clean", 32'(clean_out), 32'h0);
      tick(1);
      check("s2_edge7_clean", 32'(clean_out), 32'h1);
      check("s2_edge7_rise",  32'(rise_out),  32'h1);

      // Scenario 3: ch1 bounces 1,0,1,0,1 then settles high.
      dirty_in = 4'b0011; tick(1);
      dirty_in = 4'b0001; tick(1);
      dirty_in = 4'b0011; tick(1);
      dirty_in = 4'b0001; tick(1);
      dirty_in = 4'b0011;
      tick(6);
      check("s3_edge6_rise", 32'(rise_out), 32'h0);
      tick(1);
      check("s3_edge7_rise", 32'(rise_out), 32'h2);

      // Scenario 4: ch2 long press, release, re-press.
      dirty_in = 4'b0111;
      tick(7);
      check("s4_rise", 32'(rise_out), 32'h4);
      tick(19);
      check("s4_hold_early", 32'(held_out), 32'h0);
      tick(1);
      check("s4_hold_fire", 32'(held_out), 32'h4);
      tick(20);
      dirty_in = 4'b0011;
      tick(7);
      check("s4_fall", 32'(fall_out), 32'h4);
      dirty_in = 4'b0111;
      tick(7);
      check("s4_rerise", 32'(rise_out), 32'h4);
      tick(20);
      check("s4_rehold", 32'(held_out), 32'h4);

      // Scenario 5: ch3 rises while ch0 falls on the same edge.
      dirty_in = 4'b1110;
      tick(7);
      check("s5_rise",    32'(rise_out),    32'h8);
      check("s5_fall",    32'(fall_out),    32'h1);
      check("s5_changed", 32'(changed_out), 32'h1);
      tick(1);
      check("s5_changed_off", 32'(changed_out), 32'h0);

      // Scenario 6: asynchronous reset mid-count, then mid-hold.
      dirty_in = 4'b0110;
      tick(5);
      #1 rst_n_in = 1'b0;
      #1 check("s6_midcount_clean", 32'(clean_out), 32'h0);
      check_all_zero("s6_midcount_all");
      dirty_in = 4'b0100;
      tick(2);
      rst_n_in = 1'b1;
      tick(7);
      check("s6_rise_a", 32'(rise_out), 32'h4);
      tick(10);
      #1 rst_n_in = 1'b0;
      #1 check("s6_midhold_clean", 32'(clean_out), 32'h0);
      check_all_zero("s6_midhold_all");
      tick(2);
      rst_n_in = 1'b1;
      tick(6);
      check("s6_edge6_clean", 32'(clean_out), 32'h0);
      tick(1);
      check("s6_rise_b", 32'(rise_out), 32'h4);
      tick(19);
      check("s6_hold_early", 32'(held_out), 32'h0);
      tick(1);
      check("s6_hold_fire", 32'(held_out), 32'h4);

      // Randomized bouncing presses with occasional asynchronous resets.
      for (int ch = 0; ch < N; ch++) begin
         left[ch]   = 0;
         bounce[ch] = 0;
         tgt[ch]    = 1'b0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick(1);
         for (int ch = 0; ch < N; ch++) begin
            if (left[ch] == 0) begin
               tgt[ch]    = 1'($urandom_range(0, 1));
               left[ch]   = int'($urandom_range(1, 45));
               bounce[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            end
            d[ch] = (bounce[ch] > 0) ? 1'($urandom_range(0, 1)) : tgt[ch];
            if (bounce[ch] > 0) bounce[ch]--;
            left[ch]--;
         end
         dirty_in = d;
         if ($urandom_range(0, 799) == 0) begin
            #1 rst_n_in = 1'b0;
            #1 check_all_zero("rand_reset_all");
            #1 rst_n_in = 1'b1;
         end
      end

      tick(5);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
